// File: rtl/jtag_seq_pkg.sv
// ----------------------------------------------------------------------------
// jtag_seq_pkg
// Shared definitions for the JTAG command sequencer:
//   - USEROP opcode values
//   - FSM state encoding
//   - USERDATA capture view selection
//   - bit positions of the flags inside the status word
// No ports (package).
// ----------------------------------------------------------------------------
package jtag_seq_pkg;

    // Opcodes carried in the TAP USEROP register; anything else is a NOP
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_STATUS   = 8'h04;
    localparam logic [7:0] OP_CLR_ERR  = 8'h05;

    // Sequencer states: waiting for a command, or holding a bus request
    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    // What the USERDATA capture path presents
    typedef enum logic {
        RDATA  = 1'b0,
        STATUS = 1'b1
    } view_e;

    // Status word flag positions
    localparam int ST_BUSY = 31;
    localparam int ST_TMO  = 30;
    localparam int ST_BERR = 29;
    localparam int ST_OVR  = 28;

endpackage

// File: rtl/jtag_seq_watchdog.sv
// ----------------------------------------------------------------------------
// jtag_seq_watchdog
// Clear/enable cycle counter guarding a pending bus request.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   forces the count back to zero
//   en_i    counts one per clock while high
//   tc_o    terminal count: high during the TIMEOUT-th enabled cycle
// ----------------------------------------------------------------------------
module jtag_seq_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count holds the number of enabled cycles already elapsed, so the
    // terminal count fires in the cycle that completes TIMEOUT of them
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/jtag_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// jtag_cmd_sequencer
// Turns TAP USEROP/USERDATA updates into single-beat bus transactions on tck.
// Each rising edge of user_op_rdy is one command (SET_ADDR, WRITE, READ,
// STATUS, CLR_ERR, else NOP). Read data or the status word is returned on
// user_rdata for the USERDATA capture.
// Build option: define JTAG_SEQ_AUTOINC_EN to advance the address by
// ADDR_STEP after every error-free acknowledged transaction.
// Ports:
//   tck, trst                         clock, async active-low reset
//   user_op, user_op_rdy, user_wdata  TAP user register inputs
//   user_rdata                        TAP USERDATA capture value
//   bus_req, bus_we, bus_addr,
//   bus_wdata                         bus request (held until ack/timeout)
//   bus_ack, bus_err, bus_rdata       bus response
//   busy                              high while a transaction is pending
// ----------------------------------------------------------------------------
module jtag_cmd_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 8,
    parameter int TIMEOUT   = 255,
    parameter int ADDR_STEP = 4
) (
    input  logic              tck,
    input  logic              trst,
    input  logic [OP_W-1:0]   user_op,
    input  logic              user_op_rdy,
    input  logic [DATA_W-1:0] user_wdata,
    output logic [DATA_W-1:0] user_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

`ifdef JTAG_SEQ_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    state_e            state_q;
    view_e             view_q;
    logic              user_op_rdy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [OP_W-1:0]   last_op_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic              busy_q;
    logic              tmo_err_q;
    logic              bus_err_q;
    logic              overrun_q;
    logic              cmd_stb;
    logic              wd_tc;
    logic [DATA_W-1:0] status_w;

    // One command per rising edge, however long the TAP holds the strobe
    assign cmd_stb = user_op_rdy & ~user_op_rdy_q;

    jtag_seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (16)
    ) u_watchdog (
        .clk_i  (tck),
        .rst_ni (trst),
        .clr_i  (state_q != BUS),
        .en_i   (state_q == BUS),
        .tc_o   (wd_tc)
    );

    // Command FSM; all bus-facing outputs are registered here
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q       <= IDLE;
            view_q        <= STATUS;
            user_op_rdy_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            last_op_q     <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            tmo_err_q     <= 1'b0;
            bus_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            user_op_rdy_q <= user_op_rdy;
            case (state_q)
                IDLE: begin
                    if (cmd_stb) begin
                        last_op_q <= user_op;
                        case (user_op)
                            OP_W'(OP_SET_ADDR): begin
                                addr_q <= user_wdata[ADDR_W-1:0];
                            end
                            OP_W'(OP_WRITE): begin
                                wdata_q   <= user_wdata;
                                bus_we_q  <= 1'b1;
                                bus_req_q <= 1'b1;
                                busy_q    <= 1'b1;
                                state_q   <= BUS;
                            end
                            OP_W'(OP_READ): begin
                                bus_we_q  <= 1'b0;
                                bus_req_q <= 1'b1;
                                busy_q    <= 1'b1;
                                state_q   <= BUS;
                            end
                            OP_W'(OP_STATUS): begin
                                view_q <= STATUS;
                            end
                            OP_W'(OP_CLR_ERR): begin
                                tmo_err_q <= 1'b0;
                                bus_err_q <= 1'b0;
                                overrun_q <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                BUS: begin
                    // Commands arriving mid-transaction are lost; flag it
                    if (cmd_stb) begin
                        overrun_q <= 1'b1;
                    end
                    // An ack in the watchdog's final cycle still completes normally
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                        if (bus_err) begin
                            bus_err_q <= 1'b1;
                        end else if (AUTOINC) begin
                            addr_q <= addr_q + ADDR_W'(ADDR_STEP);
                        end
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata;
                            view_q  <= RDATA;
                        end
                    end else if (wd_tc) begin
                        tmo_err_q <= 1'b1;
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status word: flags in the top nibble, last accepted opcode at the bottom
    always_comb begin
        status_w             = '0;
        status_w[ST_BUSY]    = busy_q;
        status_w[ST_TMO]     = tmo_err_q;
        status_w[ST_BERR]    = bus_err_q;
        status_w[ST_OVR]     = overrun_q;
        status_w[OP_W-1:0]   = last_op_q;
    end

    assign user_rdata = (view_q == RDATA) ? rdata_q : status_w;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_jtag_cmd_sequencer
// Directed bench for jtag_cmd_sequencer (TIMEOUT = 8). Expected bus
// transactions and read data are queued when a command is issued and popped
// when the DUT presents the request or the read result.
// Honours JTAG_SEQ_AUTOINC_EN the same way as the design build.
// ----------------------------------------------------------------------------
module tb_jtag_cmd_sequencer;

    localparam int TMO = 8;

    logic        tck = 1'b0;
    logic        trst;
    logic [7:0]  user_op;
    logic        user_op_rdy;
    logic [31:0] user_wdata;
    logic [31:0] user_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;
    logic        busy;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        expQ[$];
    logic [31:0] rdQ[$];
    logic [31:0] modelAddr;
    int          compared   = 0;
    int          mismatched = 0;
    int          reqCycles;

    jtag_cmd_sequencer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .OP_W      (8),
        .TIMEOUT   (TMO),
        .ADDR_STEP (4)
    ) dut (
        .tck         (tck),
        .trst        (trst),
        .user_op     (user_op),
        .user_op_rdy (user_op_rdy),
        .user_wdata  (user_wdata),
        .user_rdata  (user_rdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .bus_rdata   (bus_rdata),
        .busy        (busy)
    );

    // 10 ns tck
    always #5 tck = ~tck;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] bench did not finish");
    end

    // Expected status word built from individual fields
    function automatic logic [31:0] expStatus(input logic b, input logic t,
                                              input logic e, input logic o,
                                              input logic [7:0] op);
        expStatus = {b, t, e, o, 20'h0, op};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Raise the USEROP strobe at a falling edge; returns one cycle after the
    // sampling edge with the strobe still high
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] data);
        @(negedge tck);
        user_op     = op;
        user_wdata  = data;
        user_op_rdy = 1'b1;
        @(negedge tck);
    endtask

    task automatic releaseStrobe();
        user_op_rdy = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] data);
        applyStimulus(op, data);
        releaseStrobe();
    endtask

    task automatic pushTxn(input logic we, input logic [31:0] wdata);
        txn_t t;
        t.we    = we;
        t.addr  = modelAddr;
        t.wdata = wdata;
        expQ.push_back(t);
    endtask

    // Pop the oldest expected transaction and compare it with the request
    task automatic checkTxn(output txn_t t);
        checkOutput("sb_depth", expQ.size(), 1);
        if (expQ.size() > 0) begin
            t = expQ.pop_front();
        end else begin
            t.we = 1'b0; t.addr = '0; t.wdata = '0;
        end
        checkOutput("req_up", bus_req, 1);
        checkOutput("busy_up", busy, 1);
        checkOutput("bus_we", bus_we, t.we);
        checkOutput("bus_addr", bus_addr, t.addr);
        if (t.we) begin
            checkOutput("bus_wdata", bus_wdata, t.wdata);
        end
    endtask

    // Act as the target: ack after 'delay' further cycles
    task automatic serviceBus(input int delay, input logic err, input logic [31:0] rd);
        txn_t t;
        checkTxn(t);
        repeat (delay) @(negedge tck);
        checkOutput("req_hold", bus_req, 1);
        checkOutput("addr_stable", bus_addr, t.addr);
        bus_ack   = 1'b1;
        bus_err   = err;
        bus_rdata = rd;
        if (!t.we) begin
            rdQ.push_back(rd);
        end
`ifdef JTAG_SEQ_AUTOINC_EN
        if (!err) begin
            modelAddr = modelAddr + 32'd4;
        end
`endif
        @(negedge tck);
        bus_ack = 1'b0;
        bus_err = 1'b0;
        checkOutput("req_drop", bus_req, 0);
        checkOutput("busy_drop", busy, 0);
    endtask

    task automatic checkReadData();
        logic [31:0] exp;
        exp = (rdQ.size() > 0) ? rdQ.pop_front() : 32'hxxxx_xxxx;
        checkOutput("user_rdata_rd", user_rdata, exp);
    endtask

    initial begin
        txn_t t;
        trst        = 1'b0;
        user_op     = '0;
        user_op_rdy = 1'b0;
        user_wdata  = '0;
        bus_ack     = 1'b0;
        bus_err     = 1'b0;
        bus_rdata   = '0;
        modelAddr   = '0;

        // Reset state
        repeat (2) @(negedge tck);
        checkOutput("rst_req", bus_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rdata", user_rdata, 0);
        checkOutput("rst_addr", bus_addr, 0);
        trst = 1'b1;
        @(negedge tck);

        // SET_ADDR then WRITE acked after 3 cycles
        $display("[TB] write sequence");
        issue(8'h01, 32'h1000_0000);
        checkOutput("setaddr_idle", busy, 0);
        modelAddr = 32'h1000_0000;
        pushTxn(1'b1, 32'hDEAD_BEEF);
        issue(8'h02, 32'hDEAD_BEEF);
        serviceBus(3, 1'b0, 32'h0);

        // READ with the strobe held high throughout: one command only
        $display("[TB] read sequence");
        pushTxn(1'b0, 32'h0);
        applyStimulus(8'h03, 32'h0);
        serviceBus(1, 1'b0, 32'h1234_5678);
        repeat (2) @(negedge tck);
        releaseStrobe();
        checkReadData();
        issue(8'h04, 32'h0);
        checkOutput("status_after_read", user_rdata, expStatus(0, 0, 0, 0, 8'h04));

        // READ with no ack: request lasts exactly TIMEOUT cycles
        $display("[TB] timeout sequence");
        pushTxn(1'b0, 32'h0);
        issue(8'h03, 32'h0);
        checkTxn(t);
        reqCycles = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge tck);
            if (!bus_req) break;
            reqCycles++;
        end
        checkOutput("tmo_cycles", reqCycles, TMO);
        checkOutput("tmo_status_live", user_rdata, expStatus(0, 1, 0, 0, 8'h03));
        issue(8'h04, 32'h0);
        checkOutput("tmo_status", user_rdata, expStatus(0, 1, 0, 0, 8'h04));
        issue(8'h05, 32'h0);
        checkOutput("clr_status_live", user_rdata, expStatus(0, 0, 0, 0, 8'h05));
        issue(8'h04, 32'h0);
        checkOutput("clr_status", user_rdata, expStatus(0, 0, 0, 0, 8'h04));

        // Second command while a WRITE is pending is dropped
        $display("[TB] overrun sequence");
        pushTxn(1'b1, 32'hCAFE_F00D);
        issue(8'h02, 32'hCAFE_F00D);
        issue(8'h03, 32'h0);
        checkOutput("ovr_busy_status", user_rdata, expStatus(1, 0, 0, 1, 8'h02));
        serviceBus(1, 1'b0, 32'h0);
        checkOutput("ovr_done_status", user_rdata, expStatus(0, 0, 0, 1, 8'h02));
        repeat (3) @(negedge tck);
        checkOutput("ovr_no_read", bus_req, 0);
        issue(8'h05, 32'h0);

        // Ack arriving in the watchdog's final cycle wins over the timeout
        $display("[TB] ack at timeout boundary");
        pushTxn(1'b0, 32'h0);
        issue(8'h03, 32'h0);
        serviceBus(TMO - 1, 1'b0, 32'hA5A5_5A5A);
        checkReadData();
        issue(8'h04, 32'h0);
        checkOutput("edge_status", user_rdata, expStatus(0, 0, 0, 0, 8'h04));

        // Address wrap, then an erroring write that must not advance it
        $display("[TB] address step and bus error");
        issue(8'h01, 32'hFFFF_FFFC);
        modelAddr = 32'hFFFF_FFFC;
        pushTxn(1'b1, 32'h1111_1111);
        issue(8'h02, 32'h1111_1111);
        serviceBus(0, 1'b0, 32'h0);
        pushTxn(1'b1, 32'h2222_2222);
        issue(8'h02, 32'h2222_2222);
        serviceBus(2, 1'b1, 32'h0);
        pushTxn(1'b1, 32'h3333_3333);
        issue(8'h02, 32'h3333_3333);
        serviceBus(1, 1'b0, 32'h0);
        issue(8'h04, 32'h0);
        checkOutput("berr_status", user_rdata, expStatus(0, 0, 1, 0, 8'h04));
        issue(8'h05, 32'h0);

        // Reset during a pending READ, then a normal READ afterwards
        $display("[TB] reset mid-transaction");
        pushTxn(1'b0, 32'h0);
        issue(8'h03, 32'h0);
        checkTxn(t);
        trst = 1'b0;
        #1;
        checkOutput("arst_req", bus_req, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_rdata", user_rdata, 0);
        @(negedge tck);
        trst = 1'b1;
        modelAddr = '0;
        @(negedge tck);
        pushTxn(1'b0, 32'h0);
        issue(8'h03, 32'h0);
        serviceBus(2, 1'b0, 32'h0BAD_F00D);
        checkReadData();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
